// File: rtl/snake_game_ctrl.sv
// Game sequencer for the snake body-memory block: tick generation, direction latch,
// move/shift handshake, collision and food evaluation. Define WALL_COLLIDE_EN for wall deaths.
module snake_game_ctrl #(
  parameter int H        = 32,
  parameter int V        = 32,
  parameter int TICK_DIV = 2500000,
  parameter int SETTLE   = 2,
  localparam int XBITS   = (H > 1) ? $clog2(H) : 1,
  localparam int YBITS   = (V > 1) ? $clog2(V) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic [3:0]       btn,
  input  logic             end_shift,
  input  logic             self_col,
  input  logic [XBITS-1:0] head_x,
  input  logic [YBITS-1:0] head_y,
  input  logic [XBITS-1:0] food_x,
  input  logic [YBITS-1:0] food_y,
  output logic             snake_rst,
  output logic             move_enable,
  output logic [1:0]       move,
  output logic             shift,
  output logic             food_req,
  output logic [7:0]       score,
  output logic             game_over,
  output logic             running
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] TICK_LAST   = CW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  typedef enum logic [3:0] {
    IDLE, INIT, WAIT_TICK, MOVE, SHIFT, WAIT_SHIFT, SETTLE_S, CHECK, OVER
  } state_t;

  state_t        state;
  logic [1:0]    dir;
  logic [1:0]    pending;
  logic [CW-1:0] tick_cnt;
  logic [SW-1:0] settle_cnt;

  logic          btn_valid;
  logic [1:0]    btn_dir;
  logic          accept;
  logic          wall_hit;

  // NOTE: every signal written here gets a default first, otherwise the
  // unmatched case arms would infer latches.
  always_comb begin
    btn_valid = 1'b0;
    btn_dir   = 2'd0;
    case (btn)
      4'b0001: begin btn_valid = 1'b1; btn_dir = 2'd0; end
      4'b0010: begin btn_valid = 1'b1; btn_dir = 2'd1; end
      4'b0100: begin btn_valid = 1'b1; btn_dir = 2'd2; end
      4'b1000: begin btn_valid = 1'b1; btn_dir = 2'd3; end
      default: ;
    endcase
  end

  // Reversal is the direction with bit 1 flipped (right<->left, up<->down).
  assign accept = btn_valid && (btn_dir != (dir ^ 2'd2));

`ifdef WALL_COLLIDE_EN
  always_comb begin
    wall_hit = 1'b0;
    case (pending)
      2'd0: wall_hit = (head_x == XBITS'(H - 1));
      2'd1: wall_hit = (head_y == YBITS'(V - 1));
      2'd2: wall_hit = (head_x == '0);
      2'd3: wall_hit = (head_y == '0);
      default: ;
    endcase
  end
`else
  assign wall_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      dir         <= 2'd0;
      pending     <= 2'd0;
      tick_cnt    <= '0;
      settle_cnt  <= '0;
      snake_rst   <= 1'b0;
      move_enable <= 1'b0;
      move        <= 2'd0;
      shift       <= 1'b0;
      food_req    <= 1'b0;
      score       <= 8'd0;
      game_over   <= 1'b0;
      running     <= 1'b0;
    end else begin
      snake_rst   <= 1'b0;
      move_enable <= 1'b0;
      shift       <= 1'b0;
      food_req    <= 1'b0;

      if (state != IDLE && state != OVER && accept)
        pending <= btn_dir;

      // Strobes are registered on entry, so each one is high during its own state.
      case (state)
        IDLE, OVER: begin
          if (start) begin
            state     <= INIT;
            snake_rst <= 1'b1;
            food_req  <= 1'b1;
            score     <= 8'd0;
            game_over <= 1'b0;
          end
        end
        INIT: begin
          dir      <= 2'd0;
          pending  <= 2'd0;
          tick_cnt <= '0;
          running  <= 1'b1;
          state    <= WAIT_TICK;
        end
        WAIT_TICK: begin
          if (!pause) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              if (wall_hit) begin
                state     <= OVER;
                game_over <= 1'b1;
                running   <= 1'b0;
              end else begin
                state       <= MOVE;
                dir         <= pending;
                move        <= pending;
                move_enable <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + CW'(1);
            end
          end
        end
        MOVE: begin
          shift <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: state <= WAIT_SHIFT;
        WAIT_SHIFT: begin
          if (end_shift) begin
            settle_cnt <= '0;
            state      <= SETTLE_S;
          end
        end
        SETTLE_S: begin
          if (settle_cnt == SETTLE_LAST) state <= CHECK;
          else settle_cnt <= settle_cnt + SW'(1);
        end
        CHECK: begin
          if (self_col) begin
            state     <= OVER;
            game_over <= 1'b1;
            running   <= 1'b0;
          end else begin
            if (head_x == food_x && head_y == food_y) begin
              if (score != 8'hFF) score <= score + 8'd1;
              food_req <= 1'b1;
            end
            state <= WAIT_TICK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl: direction table plus directed game sequences.
// Honours WALL_COLLIDE_EN for the wall-hit expectation.
module tb_snake_game_ctrl;

  localparam int TICK_DIV = 8;
  localparam int SETTLE   = 2;
  localparam int BOUND    = 40;

  logic       clk = 1'b0;
  logic       reset, start, pause, end_shift, self_col;
  logic [3:0] btn;
  logic [4:0] head_x, head_y, food_x, food_y;
  logic       snake_rst, move_enable, shift, food_req, game_over, running;
  logic [1:0] move;
  logic [7:0] score;

  int errors = 0;
  int checks = 0;
  int strobe_viol = 0;

  typedef struct {
    logic [3:0] btn_a;
    logic [3:0] btn_b;
    logic [1:0] exp_move;
  } dir_vec_t;

  dir_vec_t dir_vecs [8];

  snake_game_ctrl #(.H(32), .V(32), .TICK_DIV(TICK_DIV), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .btn(btn),
    .end_shift(end_shift), .self_col(self_col),
    .head_x(head_x), .head_y(head_y), .food_x(food_x), .food_y(food_y),
    .snake_rst(snake_rst), .move_enable(move_enable), .move(move), .shift(shift),
    .food_req(food_req), .score(score), .game_over(game_over), .running(running)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!reset && (int'(snake_rst) + int'(move_enable) + int'(shift)) > 1)
      strobe_viol++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Advances until move_enable is seen or the bound runs out.
  task automatic wait_move(output int cycles);
    cycles = 0;
    while (move_enable !== 1'b1 && cycles < BOUND) begin
      tick();
      cycles++;
    end
    check("tick_reached", 32'(move_enable), 1);
  endtask

  // Called in the MOVE cycle; returns one cycle after CHECK has resolved.
  task automatic complete_move(input int gap);
    int stray;
    stray = 0;
    tick();
    check("shift_after_move", 32'(shift), 1);
    check("move_enable_one_cycle", 32'(move_enable), 0);
    for (int i = 0; i < gap; i++) begin
      tick();
      if (shift || move_enable) stray++;
    end
    check("no_stray_strobe", 32'(stray), 0);
    end_shift = 1'b1;
    tick();
    end_shift = 1'b0;
    repeat (SETTLE) tick();
    tick();
  endtask

  initial begin
    int cyc;
    int seen;

    dir_vecs[0] = '{4'b0100, 4'b0000, 2'd0};  // reversal of right
    dir_vecs[1] = '{4'b0011, 4'b0000, 2'd0};  // multi-hot
    dir_vecs[2] = '{4'b0100, 4'b0010, 2'd1};  // left rejected, up wins
    dir_vecs[3] = '{4'b1000, 4'b0000, 2'd1};  // reversal of up
    dir_vecs[4] = '{4'b0100, 4'b0001, 2'd0};  // last valid press wins
    dir_vecs[5] = '{4'b1000, 4'b0000, 2'd3};
    dir_vecs[6] = '{4'b0010, 4'b0000, 2'd3};  // reversal of down
    dir_vecs[7] = '{4'b0100, 4'b0000, 2'd2};

    reset = 1'b1; start = 1'b0; pause = 1'b0; btn = 4'b0; end_shift = 1'b0;
    self_col = 1'b0; head_x = 5'd0; head_y = 5'd0; food_x = 5'd5; food_y = 5'd5;
    repeat (3) tick();
    check("rst_snake_rst", 32'(snake_rst), 0);
    check("rst_move_enable", 32'(move_enable), 0);
    check("rst_move", 32'(move), 0);
    check("rst_shift", 32'(shift), 0);
    check("rst_food_req", 32'(food_req), 0);
    check("rst_score", 32'(score), 0);
    check("rst_game_over", 32'(game_over), 0);
    check("rst_running", 32'(running), 0);
    reset = 1'b0;
    tick();
    check("idle_running", 32'(running), 0);

    // First game tick timing.
    start = 1'b1; tick(); start = 1'b0;
    check("init_snake_rst", 32'(snake_rst), 1);
    check("init_food_req", 32'(food_req), 1);
    check("init_running", 32'(running), 0);
    tick();
    check("wait_snake_rst_low", 32'(snake_rst), 0);
    check("wait_food_req_low", 32'(food_req), 0);
    check("wait_running", 32'(running), 1);
    wait_move(cyc);
    check("first_tick_cycles", 32'(cyc), TICK_DIV);
    check("first_move_dir", 32'(move), 0);
    complete_move(5);
    check("first_no_food", 32'(food_req), 0);
    check("first_score", 32'(score), 0);
    check("first_running", 32'(running), 1);

    // Direction latch vectors.
    for (int i = 0; i < 8; i++) begin
      btn = dir_vecs[i].btn_a; tick();
      btn = dir_vecs[i].btn_b; tick();
      btn = 4'b0;
      wait_move(cyc);
      check($sformatf("dir_vec%0d_move", i), 32'(move), 32'(dir_vecs[i].exp_move));
      complete_move(2);
    end

    // Food hit and score saturation.
    head_x = 5'd17; head_y = 5'd16; food_x = 5'd17; food_y = 5'd16;
    wait_move(cyc);
    complete_move(3);
    check("food_req_on_hit", 32'(food_req), 1);
    check("score_first_hit", 32'(score), 1);
    tick();
    check("food_req_pulse", 32'(food_req), 0);
    for (int i = 0; i < 254; i++) begin
      wait_move(cyc);
      complete_move(1);
    end
    check("score_reach_255", 32'(score), 255);
    wait_move(cyc);
    complete_move(1);
    check("score_saturated", 32'(score), 255);
    check("food_req_at_sat", 32'(food_req), 1);
    food_x = 5'd5; food_y = 5'd5;

    // Pause freezes the counter; start while running is ignored.
    repeat (3) tick();
    pause = 1'b1; start = 1'b1;
    seen = 0;
    repeat (20) begin
      tick();
      if (move_enable || snake_rst) seen++;
    end
    pause = 1'b0; start = 1'b0;
    check("pause_no_move", 32'(seen), 0);
    check("start_ignored_score", 32'(score), 255);
    wait_move(cyc);
    check("pause_resume_cycles", 32'(cyc), TICK_DIV - 3);
    complete_move(2);

    // Self collision ends the game; start restarts it.
    self_col = 1'b1;
    wait_move(cyc);
    complete_move(2);
    self_col = 1'b0;
    check("col_game_over", 32'(game_over), 1);
    check("col_running", 32'(running), 0);
    seen = 0;
    repeat (20) begin
      tick();
      if (shift || move_enable) seen++;
    end
    check("over_no_shift", 32'(seen), 0);
    check("over_holds", 32'(game_over), 1);
    start = 1'b1; tick(); start = 1'b0;
    check("restart_snake_rst", 32'(snake_rst), 1);
    check("restart_score", 32'(score), 0);
    check("restart_game_over", 32'(game_over), 0);

    // Reset while waiting for end_shift.
    head_x = 5'd5; head_y = 5'd5;
    tick();
    wait_move(cyc);
    complete_move(1);
    check("pre_reset_score", 32'(score), 1);
    head_x = 5'd0; head_y = 5'd0;
    wait_move(cyc);
    tick();
    tick();
    check("in_wait_shift", 32'(running), 1);
    reset = 1'b1; tick();
    check("mid_rst_running", 32'(running), 0);
    check("mid_rst_score", 32'(score), 0);
    check("mid_rst_strobes", {28'b0, snake_rst, move_enable, shift, food_req}, 0);
    check("mid_rst_move", 32'(move), 0);
    reset = 1'b0;
    end_shift = 1'b1; tick(); end_shift = 1'b0;
    seen = 0;
    repeat (10) begin
      tick();
      if (snake_rst || shift || move_enable || running) seen++;
    end
    check("idle_ignores_end_shift", 32'(seen), 0);

    // Head at the right wall while moving right.
    start = 1'b1; tick(); start = 1'b0;
    head_x = 5'd31; head_y = 5'd3;
    cyc = 0; seen = 0;
    while (move_enable !== 1'b1 && game_over !== 1'b1 && cyc < BOUND) begin
      tick();
      cyc++;
      if (shift) seen++;
    end
`ifdef WALL_COLLIDE_EN
    check("wall_game_over", 32'(game_over), 1);
    check("wall_no_move", 32'(move_enable), 0);
    tick();
    check("wall_no_shift", 32'(seen + int'(shift)), 0);
`else
    check("wrap_move_enable", 32'(move_enable), 1);
    check("wrap_move", 32'(move), 0);
    complete_move(1);
    check("wrap_game_over", 32'(game_over), 0);
    check("wrap_running", 32'(running), 1);
`endif

    check("strobes_exclusive", 32'(strobe_viol), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
